// File: rtl/rf_writeback_arbiter_if.sv
// rtl/rf_writeback_arbiter_if.sv - writeback streams and decode pending-lookup bundle
// The master side is the core (ALU, DSP, decode). The slave side is the arbiter.
interface rf_writeback_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              alu_wb_valid;
  logic              alu_wb_ready;
  logic [ADDR_W-1:0] alu_wb_addr;
  logic [DATA_W-1:0] alu_wb_data;
  logic              dsp_wb_valid;
  logic              dsp_wb_ready;
  logic [ADDR_W-1:0] dsp_wb_addr;
  logic [DATA_W-1:0] dsp_wb_data;
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic              rs1_pending;
  logic              rs2_pending;

  modport master (
    output alu_wb_valid, alu_wb_addr, alu_wb_data,
    output dsp_wb_valid, dsp_wb_addr, dsp_wb_data,
    output rs1_addr, rs2_addr,
    input  alu_wb_ready, dsp_wb_ready, rs1_pending, rs2_pending
  );

  modport slave (
    input  alu_wb_valid, alu_wb_addr, alu_wb_data,
    input  dsp_wb_valid, dsp_wb_addr, dsp_wb_data,
    input  rs1_addr, rs2_addr,
    output alu_wb_ready, dsp_wb_ready, rs1_pending, rs2_pending
  );
endinterface

// File: rtl/rf_writeback_arbiter.sv
// rtl/rf_writeback_arbiter.sv - merges ALU and queued DSP writebacks onto one register file write port
// The ALU normally wins. DSP results wait in a FIFO that is forced through after STARVE_MAX consecutive ALU wins.
module rf_writeback_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  rf_writeback_arbiter_if.slave                bus,
  output logic [ADDR_W-1:0]                    o_rd_addr,
  output logic [DATA_W-1:0]                    o_rd_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      o_fifo_count
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [STV_W-1:0]  r_starve;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [DATA_W-1:0] r_rd_data;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_force;
  logic                  w_alu_win;
  logic                  w_pop;
  logic                  w_push;
  logic [PTR_W-1:0]      w_offset [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] w_entry_valid;
  logic                  w_rs1_hit;
  logic                  w_rs2_hit;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_force   = (r_starve == STV_W'(STARVE_MAX)) && !w_empty;
  assign w_alu_win = !w_force && bus.alu_wb_valid;
  assign w_pop     = w_force || (!bus.alu_wb_valid && !w_empty);
  // Writes to x0 are acknowledged to the DSP but never occupy a FIFO slot.
  assign w_push    = bus.dsp_wb_valid && !w_full && (bus.dsp_wb_addr != '0);

  assign bus.alu_wb_ready = !w_force;
  assign bus.dsp_wb_ready = !w_full;

  // A slot is live when its distance from the head is below the occupancy.
  always_comb begin
    w_offset      = '{default: '0};
    w_entry_valid = '0;
    w_rs1_hit     = (bus.rs1_addr == r_rd_addr);
    w_rs2_hit     = (bus.rs2_addr == r_rd_addr);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      w_offset[i]      = PTR_W'(i) - r_rd_ptr;
      w_entry_valid[i] = ({1'b0, w_offset[i]} < r_count);
      if (w_entry_valid[i] && (r_fifo_addr[i] == bus.rs1_addr)) begin
        w_rs1_hit = 1'b1;
      end
      if (w_entry_valid[i] && (r_fifo_addr[i] == bus.rs2_addr)) begin
        w_rs2_hit = 1'b1;
      end
    end
  end

  assign bus.rs1_pending = (bus.rs1_addr != '0) && w_rs1_hit;
  assign bus.rs2_pending = (bus.rs2_addr != '0) && w_rs2_hit;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= bus.dsp_wb_addr;
      r_fifo_data[r_wr_ptr] <= bus.dsp_wb_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_starve  <= '0;
      r_rd_addr <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (w_pop || w_empty) begin
        r_starve <= '0;
      end else if (w_alu_win && (r_starve != STV_W'(STARVE_MAX))) begin
        r_starve <= r_starve + 1'b1;
      end

      if (w_pop) begin
        r_rd_addr <= r_fifo_addr[r_rd_ptr];
        r_rd_data <= r_fifo_data[r_rd_ptr];
      end else if (w_alu_win) begin
        r_rd_addr <= bus.alu_wb_addr;
        r_rd_data <= bus.alu_wb_data;
      end else begin
        r_rd_addr <= '0;
        r_rd_data <= '0;
      end
    end
  end

  assign o_rd_addr    = r_rd_addr;
  assign o_rd_data    = r_rd_data;
  assign o_fifo_count = r_count;
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// tb/tb_rf_writeback_arbiter.sv - self-checking bench for rf_writeback_arbiter
module tb_rf_writeback_arbiter;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 4;
  localparam int SMAX  = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [CW-1:0] fifo_count;
  int            n_chk = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  rf_writeback_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  rf_writeback_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .bus(bus),
    .o_rd_addr(rd_addr),
    .o_rd_data(rd_data),
    .o_fifo_count(fifo_count)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          m_q[$];
  int            m_starve;
  logic [AW-1:0] m_rd_addr;
  logic [DW-1:0] m_rd_data;

  function automatic void m_reset();
    m_q.delete();
    m_starve  = 0;
    m_rd_addr = '0;
    m_rd_data = '0;
  endfunction

  function automatic bit m_force();
    return (m_starve == SMAX) && (m_q.size() > 0);
  endfunction

  function automatic bit m_pend(input logic [AW-1:0] addr);
    if (addr == '0) return 1'b0;
    if (addr == m_rd_addr) return 1'b1;
    foreach (m_q[k]) if (m_q[k].a == addr) return 1'b1;
    return 1'b0;
  endfunction

  // One clock of the reference: who writes, what the queue and starve count become.
  function automatic void m_advance();
    bit   nonempty = (m_q.size() > 0);
    bit   dsp_acc  = bus.dsp_wb_valid && (m_q.size() < DEPTH);
    ent_t e;
    if (m_force() || (!bus.alu_wb_valid && nonempty)) begin
      e = m_q.pop_front();
      m_rd_addr = e.a;
      m_rd_data = e.d;
      m_starve  = 0;
    end else if (bus.alu_wb_valid) begin
      m_rd_addr = bus.alu_wb_addr;
      m_rd_data = bus.alu_wb_data;
      m_starve  = nonempty ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
    end else begin
      m_rd_addr = '0;
      m_rd_data = '0;
      m_starve  = 0;
    end
    if (dsp_acc && (bus.dsp_wb_addr != '0)) begin
      e.a = bus.dsp_wb_addr;
      e.d = bus.dsp_wb_data;
      m_q.push_back(e);
    end
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("m_rd_addr", 64'(rd_addr), 64'(m_rd_addr));
    chk("m_rd_data", 64'(rd_data), 64'(m_rd_data));
    chk("m_fifo_count", 64'(fifo_count), 64'(m_q.size()));
    chk("m_alu_ready", 64'(bus.alu_wb_ready), 64'(!m_force()));
    chk("m_dsp_ready", 64'(bus.dsp_wb_ready), 64'(m_q.size() < DEPTH));
    chk("m_rs1_pending", 64'(bus.rs1_pending), 64'(m_pend(bus.rs1_addr)));
    chk("m_rs2_pending", 64'(bus.rs2_pending), 64'(m_pend(bus.rs2_addr)));
  endtask

  // Called just after a falling edge with inputs applied; returns after the next falling edge.
  task automatic step();
    #2;
    check_model();
    m_advance();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic dv, input logic [AW-1:0] da, input logic [DW-1:0] dd);
    bus.alu_wb_valid = av;
    bus.alu_wb_addr  = aa;
    bus.alu_wb_data  = ad;
    bus.dsp_wb_valid = dv;
    bus.dsp_wb_addr  = da;
    bus.dsp_wb_data  = dd;
  endtask

  typedef struct {
    logic          av;
    logic [AW-1:0] aa;
    logic [DW-1:0] ad;
    logic          dv;
    logic [AW-1:0] da;
    logic [DW-1:0] dd;
    logic [AW-1:0] r1;
    logic [AW-1:0] r2;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic [CW-1:0] e_cnt;
    logic          e_ardy;
    logic          e_drdy;
    logic          e_p1;
    logic          e_p2;
  } vec_t;

  function automatic vec_t mk(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                              input logic dv, input logic [AW-1:0] da, input logic [DW-1:0] dd,
                              input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                              input logic [AW-1:0] ea, input logic [DW-1:0] ed, input logic [CW-1:0] ec,
                              input logic ear, input logic edr, input logic ep1, input logic ep2);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad; v.dv = dv; v.da = da; v.dd = dd;
    v.r1 = r1; v.r2 = r2; v.e_addr = ea; v.e_data = ed; v.e_cnt = ec;
    v.e_ardy = ear; v.e_drdy = edr; v.e_p1 = ep1; v.e_p2 = ep2;
    return v;
  endfunction

  vec_t vecs[11];

  initial begin
    int            acc;
    int            alu_n;
    int            acc5_cyc;
    bit            a_acc;
    bit            d_acc;
    logic          av;
    logic          dv;
    logic [AW-1:0] aa;
    logic [AW-1:0] da;
    logic [DW-1:0] ad;
    logic [DW-1:0] dd;

    // Expected values are sampled before the edge on which the row's inputs are taken.
    vecs[0]  = mk(0, 0, 0,            0, 0,  0,     0,  0,  0,  0,            0, 1, 1, 0, 0);
    vecs[1]  = mk(1, 5, 32'hDEADBEEF, 0, 0,  0,     5,  0,  0,  0,            0, 1, 1, 0, 0);
    vecs[2]  = mk(0, 0, 0,            0, 0,  0,     5,  5,  5,  32'hDEADBEEF, 0, 1, 1, 1, 1);
    vecs[3]  = mk(0, 0, 0,            0, 0,  0,     5,  0,  0,  0,            0, 1, 1, 0, 0);
    vecs[4]  = mk(0, 0, 0,            1, 17, 'hA5,  17, 0,  0,  0,            0, 1, 1, 0, 0);
    vecs[5]  = mk(0, 0, 0,            0, 0,  0,     17, 0,  0,  0,            1, 1, 1, 1, 0);
    vecs[6]  = mk(0, 0, 0,            0, 0,  0,     17, 0,  17, 'hA5,         0, 1, 1, 1, 0);
    vecs[7]  = mk(0, 0, 0,            0, 0,  0,     17, 0,  0,  0,            0, 1, 1, 0, 0);
    vecs[8]  = mk(1, 0, 'h77,         1, 0,  'h55,  0,  0,  0,  0,            0, 1, 1, 0, 0);
    vecs[9]  = mk(0, 0, 0,            0, 0,  0,     0,  0,  0,  'h77,         0, 1, 1, 0, 0);
    vecs[10] = mk(0, 0, 0,            0, 0,  0,     0,  0,  0,  0,            0, 1, 1, 0, 0);

    drive(0, 0, 0, 0, 0, 0);
    bus.rs1_addr = '0;
    bus.rs2_addr = '0;
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].dv, vecs[i].da, vecs[i].dd);
      bus.rs1_addr = vecs[i].r1;
      bus.rs2_addr = vecs[i].r2;
      #1;
      chk($sformatf("vec%0d_rd_addr", i), 64'(rd_addr), 64'(vecs[i].e_addr));
      chk($sformatf("vec%0d_rd_data", i), 64'(rd_data), 64'(vecs[i].e_data));
      chk($sformatf("vec%0d_count", i), 64'(fifo_count), 64'(vecs[i].e_cnt));
      chk($sformatf("vec%0d_alu_ready", i), 64'(bus.alu_wb_ready), 64'(vecs[i].e_ardy));
      chk($sformatf("vec%0d_dsp_ready", i), 64'(bus.dsp_wb_ready), 64'(vecs[i].e_drdy));
      chk($sformatf("vec%0d_rs1_pend", i), 64'(bus.rs1_pending), 64'(vecs[i].e_p1));
      chk($sformatf("vec%0d_rs2_pend", i), 64'(bus.rs2_pending), 64'(vecs[i].e_p2));
      step();
    end

    // Reset in the middle of traffic: three queued entries and x16 on the write port.
    bus.rs1_addr = 16;
    bus.rs2_addr = 18;
    drive(1, 1, 1, 1, 16, 'h16); step();
    drive(1, 2, 2, 1, 17, 'h17); step();
    drive(1, 3, 3, 1, 18, 'h18); step();
    drive(0, 0, 0, 1, 19, 'h19); step();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_pre_rd_addr", 64'(rd_addr), 64'd16);
    chk("rst_pre_count", 64'(fifo_count), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("rst_rd_addr", 64'(rd_addr), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_dsp_ready", 64'(bus.dsp_wb_ready), 64'd1);
    chk("rst_alu_ready", 64'(bus.alu_wb_ready), 64'd1);
    chk("rst_rs1_pend", 64'(bus.rs1_pending), 64'd0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // FIFO fills under continuous ALU traffic; the fifth push waits for the forced pop.
    acc = 0;
    alu_n = 1;
    acc5_cyc = -1;
    for (int c = 0; c < 20 && acc < 5; c++) begin
      drive(1, AW'((alu_n % 15) + 1), DW'(32'hA000 + alu_n), 1, AW'(16 + acc % 3), DW'(32'hD000 + acc));
      #1;
      if (c == 4) begin
        chk("t3_count_full", 64'(fifo_count), 64'd4);
        chk("t3_dsp_ready_low", 64'(bus.dsp_wb_ready), 64'd0);
      end
      if (c == 9) chk("t3_forced_alu_ready", 64'(bus.alu_wb_ready), 64'd0);
      a_acc = bus.alu_wb_valid && bus.alu_wb_ready;
      d_acc = bus.dsp_wb_ready;
      step();
      if (a_acc) alu_n++;
      if (d_acc) begin
        if (acc == 4) acc5_cyc = c;
        acc++;
      end
    end
    chk("t3_fifth_push_cycle", 64'(acc5_cyc), 64'd10);
    drive(0, 0, 0, 0, 0, 0);
    repeat (6) step();

    // Single DSP entry starved by ALU traffic is forced out after STARVE_MAX ALU wins.
    alu_n = 1;
    for (int c = 0; c < 12; c++) begin
      drive(1, AW'((alu_n % 15) + 1), DW'(32'hB000 + alu_n), c == 0, 16, 32'h1234);
      #1;
      if (c == 8) chk("t4_alu_ready_before", 64'(bus.alu_wb_ready), 64'd1);
      if (c == 9) chk("t4_alu_ready_low", 64'(bus.alu_wb_ready), 64'd0);
      if (c == 10) begin
        chk("t4_rd_addr", 64'(rd_addr), 64'd16);
        chk("t4_rd_data", 64'(rd_data), 64'h1234);
        chk("t4_alu_resumes", 64'(bus.alu_wb_ready), 64'd1);
      end
      a_acc = bus.alu_wb_ready;
      step();
      if (a_acc) alu_n++;
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) step();

    // Random traffic; producers hold their request until it is taken.
    av = 0; dv = 0; aa = '0; da = '0; ad = '0; dd = '0;
    for (int c = 0; c < 400; c++) begin
      if (!av || a_acc) begin
        av = ($urandom_range(0, 3) != 0);
        aa = AW'($urandom_range(0, 18));
        ad = $urandom;
      end
      if (!dv || d_acc) begin
        dv = ($urandom_range(0, 2) == 0);
        da = AW'($urandom_range(0, 18));
        dd = $urandom;
      end
      drive(av, aa, ad, dv, da, dd);
      bus.rs1_addr = AW'($urandom_range(0, 18));
      bus.rs2_addr = AW'($urandom_range(0, 18));
      #1;
      a_acc = av && bus.alu_wb_ready;
      d_acc = dv && bus.dsp_wb_ready;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
